// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and encodings for the multi-cycle MIPS control path
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_BEQ  = 6'h04, OP_BNE = 6'h05,
                         OP_ADDI  = 6'h08, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                         OP_LW    = 6'h23, OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03,
                         FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR   = 6'h25,
                         FN_XOR = 6'h26, FN_NOR = 6'h27, FN_SLT = 6'h2A, FN_SLTU = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLTU = 4'd7,
                         ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SRA = 4'd10, ALU_LUI = 4'd11;

  localparam logic [1:0] PC_SRC_ALU = 2'd0, PC_SRC_ALUOUT = 2'd1, PC_SRC_JUMP = 2'd2;

  localparam logic [1:0] SRCB_B = 2'd0, SRCB_FOUR = 2'd1, SRCB_IMM = 2'd2, SRCB_BOFF = 2'd3;

  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    case (op)
      OP_SLTI:  return ALU_SLT;
      OP_SLTIU: return ALU_SLTU;
      OP_ANDI:  return ALU_AND;
      OP_ORI:   return ALU_OR;
      OP_XORI:  return ALU_XOR;
      OP_LUI:   return ALU_LUI;
      default:  return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_alu_dec.sv
// rtl/mips_alu_dec.sv - R-type funct field to ALU operation decoder
module mips_alu_dec
  import mips_pkg::*;
#(
  parameter int ALUC_W = 4
) (
  input  logic [5:0]        funct,
  output logic [ALUC_W-1:0] alu_ctrl,
  output logic              valid
);

  logic [3:0] code;

  always_comb begin
    code  = ALU_ADD;
    valid = 1'b1;
    case (funct)
      FN_ADD:  code = ALU_ADD;
      FN_SUB:  code = ALU_SUB;
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_XOR:  code = ALU_XOR;
      FN_NOR:  code = ALU_NOR;
      FN_SLT:  code = ALU_SLT;
      FN_SLTU: code = ALU_SLTU;
      FN_SLL:  code = ALU_SLL;
      FN_SRL:  code = ALU_SRL;
      FN_SRA:  code = ALU_SRA;
      default: valid = 1'b0;
    endcase
  end

  assign alu_ctrl = ALUC_W'(code);

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle MIPS control FSM with memory wait-state timeout
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALUC_W      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic              zero,
  input  logic              mem_ready,
  output logic              pc_we,
  output logic [1:0]        pc_src,
  output logic              iord,
  output logic              mem_re,
  output logic              mem_we,
  output logic              ir_we,
  output logic              rf_we,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic              ext_zero,
  output logic [ALUC_W-1:0] alu_ctrl,
  output logic              inst_done,
  output logic              illegal_inst,
  output logic              bus_err,
  output logic [3:0]        state_o
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t            state, next_state;
  logic [7:0]        wait_cnt;
  logic              bus_err_q;
  logic              wait_state, timeout;
  logic [ALUC_W-1:0] r_alu_ctrl;
  logic              r_valid;

  mips_alu_dec #(.ALUC_W(ALUC_W)) u_alu_dec (
    .funct    (funct),
    .alu_ctrl (r_alu_ctrl),
    .valid    (r_valid)
  );

  assign wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // The last permitted wait cycle expires here, so the abort happens on the same edge.
  assign timeout    = wait_state && !mem_ready && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state <= next_state;
      if (timeout) bus_err_q <= 1'b1;
      if (wait_state && !mem_ready && !timeout) wait_cnt <= wait_cnt + 8'd1;
      else                                      wait_cnt <= '0;
    end
  end

  always_comb begin
    next_state   = state;
    pc_we        = 1'b0;
    pc_src       = PC_SRC_ALU;
    iord         = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    ir_we        = 1'b0;
    rf_we        = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    ext_zero     = 1'b0;
    alu_ctrl     = '0;
    inst_done    = 1'b0;
    illegal_inst = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        mem_re    = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALUC_W'(ALU_ADD);
        if (mem_ready) begin
          ir_we      = 1'b1;
          pc_we      = 1'b1;
          next_state = S_DECODE;
        end else if (timeout) begin
          next_state = S_HALT;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_BOFF;
        alu_ctrl  = ALUC_W'(ALU_ADD);
        case (opcode)
          OP_RTYPE: next_state = S_EXEC_R;
          OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: next_state = S_EXEC_I;
          OP_LW, OP_SW:   next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = S_BRANCH;
          OP_J:           next_state = S_JUMP;
          default: begin
            illegal_inst = 1'b1;
            next_state   = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_B;
        if (r_valid) begin
          alu_ctrl   = r_alu_ctrl;
          next_state = S_WB_R;
        end else begin
          illegal_inst = 1'b1;
          next_state   = S_FETCH;
        end
      end
      S_EXEC_I: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        ext_zero   = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        alu_ctrl   = ALUC_W'(imm_alu_op(opcode));
        next_state = S_WB_I;
      end
      S_WB_R, S_WB_I: begin
        rf_we      = 1'b1;
        reg_dst    = (state == S_WB_R);
        inst_done  = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        alu_ctrl   = ALUC_W'(ALU_ADD);
        next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        iord   = 1'b1;
        mem_re = 1'b1;
        if (mem_ready)    next_state = S_WB_MEM;
        else if (timeout) next_state = S_HALT;
      end
      S_MEM_WR: begin
        iord   = 1'b1;
        mem_we = 1'b1;
        if (mem_ready) begin
          inst_done  = 1'b1;
          next_state = S_FETCH;
        end else if (timeout) begin
          next_state = S_HALT;
        end
      end
      S_WB_MEM: begin
        rf_we      = 1'b1;
        mem_to_reg = 1'b1;
        inst_done  = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_B;
        alu_ctrl   = ALUC_W'(ALU_SUB);
        pc_src     = PC_SRC_ALUOUT;
        pc_we      = zero ^ (opcode == OP_BNE);
        inst_done  = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pc_we      = 1'b1;
        inst_done  = 1'b1;
        next_state = S_FETCH;
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  assign bus_err = bus_err_q;
  assign state_o = state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - randomized self-checking bench for mips_mc_ctrl
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_we, iord, mem_re, mem_we, ir_we, rf_we, reg_dst, mem_to_reg, alu_src_a;
  logic       ext_zero, inst_done, illegal_inst, bus_err;
  logic [1:0] pc_src, alu_src_b;
  logic [3:0] alu_ctrl, state_o;
  logic [20:0] all_out;

  int errors = 0;
  int checks = 0;

  int obs_cycles, obs_rf, obs_done, obs_ill, obs_pcwe, obs_memwe, obs_memre, obs_irwe;
  logic obs_regdst, obs_m2r, obs_ext, obs_last_rf, obs_last_pcwe, obs_timeout;
  logic [3:0] obs_alu;
  logic [1:0] obs_last_pcsrc;

  logic [5:0] op_tbl [14] = '{6'h00, 6'h08, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                             6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
  logic [5:0] bad_op_tbl [5] = '{6'h3F, 6'h01, 6'h10, 6'h20, 6'h3A};
  logic [5:0] fn_tbl [11] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                             6'h00, 6'h02, 6'h03};
  logic [5:0] bad_fn_tbl [4] = '{6'h01, 6'h3F, 6'h21, 6'h10};

  always #5 clk = ~clk;

  assign all_out = {pc_we, pc_src, iord, mem_re, mem_we, ir_we, rf_we, reg_dst, mem_to_reg,
                    alu_src_a, alu_src_b, ext_zero, alu_ctrl, inst_done, illegal_inst, bus_err};

  mips_mc_ctrl #(.MEM_TIMEOUT(15), .ALUC_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .pc_src(pc_src), .iord(iord), .mem_re(mem_re),
    .mem_we(mem_we), .ir_we(ir_we), .rf_we(rf_we), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_ctrl(alu_ctrl), .inst_done(inst_done),
    .illegal_inst(illegal_inst), .bus_err(bus_err), .state_o(state_o)
  );

  function automatic int ref_r_alu(input logic [5:0] f);
    case (f)
      6'h20: return 0;  6'h22: return 1;  6'h24: return 2;  6'h25: return 3;
      6'h26: return 4;  6'h27: return 5;  6'h2A: return 6;  6'h2B: return 7;
      6'h00: return 8;  6'h02: return 9;  6'h03: return 10;
      default: return -1;
    endcase
  endfunction

  function automatic int ref_i_alu(input logic [5:0] op);
    case (op)
      6'h08: return 0;  6'h0A: return 6;  6'h0B: return 7;  6'h0C: return 2;
      6'h0D: return 3;  6'h0E: return 4;  6'h0F: return 11;
      default: return -1;
    endcase
  endfunction

  task automatic exec_inst(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw);
    int fl, ml;
    bit fin;
    fl = fw; ml = mw; fin = 0;
    obs_cycles = 0; obs_rf = 0; obs_done = 0; obs_ill = 0; obs_pcwe = 0;
    obs_memwe = 0; obs_memre = 0; obs_irwe = 0;
    obs_regdst = 0; obs_m2r = 0; obs_ext = 0; obs_alu = 4'hF;
    opcode = op; funct = fn; zero = z;
    while (!fin && obs_cycles < 60) begin
      if (state_o == 4'(S_FETCH)) begin
        mem_ready = (fl == 0);
        if (fl > 0) fl--;
      end else if (state_o == 4'(S_MEM_RD) || state_o == 4'(S_MEM_WR)) begin
        mem_ready = (ml == 0);
        if (ml > 0) ml--;
      end else begin
        mem_ready = 1'($urandom);
      end
      #1;
      obs_cycles++;
      if (rf_we) begin obs_rf++; obs_regdst = reg_dst; obs_m2r = mem_to_reg; end
      if (inst_done) obs_done++;
      if (illegal_inst) obs_ill++;
      if (pc_we) obs_pcwe++;
      if (mem_we) obs_memwe++;
      if (mem_re) obs_memre++;
      if (ir_we) obs_irwe++;
      if (state_o == 4'(S_EXEC_R) || state_o == 4'(S_EXEC_I)) begin
        obs_alu = alu_ctrl; obs_ext = ext_zero;
      end
      obs_last_rf = rf_we; obs_last_pcwe = pc_we; obs_last_pcsrc = pc_src;
      if (inst_done || illegal_inst) fin = 1;
      @(negedge clk);
    end
    obs_timeout = !fin;
  endtask

  task automatic test_reset;
    reset = 1'b0; mem_ready = 1'b1; opcode = 6'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++;
      if (all_out !== 21'd0 || state_o !== 4'(S_IDLE)) begin
        errors++;
        $display("FAIL reset_hold: outputs=%h state=%0d, required 0 and IDLE", all_out, state_o);
      end
    end
    reset = 1'b1; #1;
    checks++;
    if (state_o !== 4'(S_IDLE)) begin
      errors++;
      $display("FAIL reset_release: state=%0d, required IDLE", state_o);
    end
    @(negedge clk);
    checks++;
    if (state_o !== 4'(S_FETCH)) begin
      errors++;
      $display("FAIL reset_to_fetch: state=%0d, required FETCH", state_o);
    end
  endtask

  task automatic test_add;
    exec_inst(6'h00, 6'h20, 1'b0, 0, 0);
    checks++;
    if (obs_cycles !== 4) begin
      errors++;
      $display("FAIL add_cycles: got %0d, required 4", obs_cycles);
    end
    checks++;
    if (obs_rf !== 1 || obs_last_rf !== 1'b1 || obs_regdst !== 1'b1) begin
      errors++;
      $display("FAIL add_wb: rf_cnt=%0d last=%b reg_dst=%b, required 1 1 1", obs_rf, obs_last_rf, obs_regdst);
    end
    checks++;
    if (obs_done !== 1 || obs_alu !== 4'd0) begin
      errors++;
      $display("FAIL add_done_alu: done=%0d alu=%0d, required 1 0", obs_done, obs_alu);
    end
  endtask

  task automatic test_lw_wait;
    exec_inst(6'h23, 6'h00, 1'b0, 0, 2);
    checks++;
    if (obs_cycles !== 7) begin
      errors++;
      $display("FAIL lw_cycles: got %0d, required 7", obs_cycles);
    end
    checks++;
    if (obs_rf !== 1 || obs_last_rf !== 1'b1 || obs_m2r !== 1'b1 || obs_regdst !== 1'b0) begin
      errors++;
      $display("FAIL lw_wb: rf_cnt=%0d last=%b m2r=%b reg_dst=%b, required 1 1 1 0",
               obs_rf, obs_last_rf, obs_m2r, obs_regdst);
    end
    checks++;
    if (obs_memre !== 4) begin
      errors++;
      $display("FAIL lw_mem_re: got %0d cycles, required 4", obs_memre);
    end
  endtask

  task automatic test_branch;
    exec_inst(6'h04, 6'h00, 1'b1, 0, 0);
    checks++;
    if (obs_cycles !== 3 || obs_last_pcwe !== 1'b1 || obs_last_pcsrc !== 2'd1) begin
      errors++;
      $display("FAIL beq_taken: cycles=%0d pc_we=%b pc_src=%0d, required 3 1 1",
               obs_cycles, obs_last_pcwe, obs_last_pcsrc);
    end
    exec_inst(6'h05, 6'h00, 1'b1, 0, 0);
    checks++;
    if (obs_cycles !== 3 || obs_last_pcwe !== 1'b0 || obs_pcwe !== 1) begin
      errors++;
      $display("FAIL bne_not_taken: cycles=%0d pc_we=%b pc_we_cnt=%0d, required 3 0 1",
               obs_cycles, obs_last_pcwe, obs_pcwe);
    end
  endtask

  task automatic test_illegal;
    exec_inst(6'h3F, 6'h20, 1'b0, 0, 0);
    checks++;
    if (obs_ill !== 1 || obs_cycles !== 2 || obs_rf !== 0 || obs_memwe !== 0 || obs_done !== 0) begin
      errors++;
      $display("FAIL illegal_op: ill=%0d cycles=%0d rf=%0d memwe=%0d done=%0d, required 1 2 0 0 0",
               obs_ill, obs_cycles, obs_rf, obs_memwe, obs_done);
    end
    checks++;
    if (state_o !== 4'(S_FETCH)) begin
      errors++;
      $display("FAIL illegal_next: state=%0d, required FETCH", state_o);
    end
  endtask

  task automatic test_random;
    logic [5:0] op, fn;
    logic z;
    int fw, mw, ra, ia, e_cycles, e_rf, e_pcwe, e_memwe, e_memre;
    bit is_r, is_i, is_lw, is_sw, is_br, is_j, e_ill;
    for (int n = 0; n < 40; n++) begin
      op = op_tbl[$urandom_range(0, 13)];
      if (op == 6'h3F) op = bad_op_tbl[$urandom_range(0, 4)];
      fn = ($urandom_range(0, 4) == 0) ? bad_fn_tbl[$urandom_range(0, 3)]
                                       : fn_tbl[$urandom_range(0, 10)];
      z = 1'($urandom); fw = $urandom_range(0, 3); mw = $urandom_range(0, 3);
      ra = ref_r_alu(fn); ia = ref_i_alu(op);
      is_r = (op == 6'h00); is_i = (ia >= 0); is_lw = (op == 6'h23); is_sw = (op == 6'h2B);
      is_br = (op == 6'h04 || op == 6'h05); is_j = (op == 6'h02);
      e_ill = (is_r && ra < 0) || !(is_r || is_i || is_lw || is_sw || is_br || is_j);
      if (is_r)                e_cycles = (ra >= 0) ? 4 : 3;
      else if (is_i || is_sw)  e_cycles = 4;
      else if (is_lw)          e_cycles = 5;
      else if (is_br || is_j)  e_cycles = 3;
      else                     e_cycles = 2;
      e_cycles += fw + ((is_lw || is_sw) ? mw : 0);
      e_rf    = ((is_r && ra >= 0) || is_i || is_lw) ? 1 : 0;
      e_pcwe  = 1 + ((is_j || (op == 6'h04 && z) || (op == 6'h05 && !z)) ? 1 : 0);
      e_memwe = is_sw ? mw + 1 : 0;
      e_memre = fw + 1 + (is_lw ? mw + 1 : 0);
      exec_inst(op, fn, z, fw, mw);
      checks++;
      if (obs_timeout || obs_cycles !== e_cycles) begin
        errors++;
        $display("FAIL rnd%0d_cycles op=%h fn=%h: got %0d, required %0d", n, op, fn, obs_cycles, e_cycles);
      end
      checks++;
      if (obs_rf !== e_rf || (e_rf == 1 && obs_last_rf !== 1'b1)) begin
        errors++;
        $display("FAIL rnd%0d_rf op=%h: cnt=%0d, required %0d at retire", n, op, obs_rf, e_rf);
      end
      checks++;
      if (obs_regdst !== (e_rf == 1 && is_r) || obs_m2r !== is_lw) begin
        errors++;
        $display("FAIL rnd%0d_wbsel op=%h: reg_dst=%b m2r=%b, required %b %b",
                 n, op, obs_regdst, obs_m2r, (e_rf == 1 && is_r), is_lw);
      end
      checks++;
      if (obs_done !== int'(!e_ill) || obs_ill !== int'(e_ill)) begin
        errors++;
        $display("FAIL rnd%0d_retire op=%h fn=%h: done=%0d ill=%0d, required %0d %0d",
                 n, op, fn, obs_done, obs_ill, !e_ill, e_ill);
      end
      checks++;
      if (obs_pcwe !== e_pcwe || obs_irwe !== 1) begin
        errors++;
        $display("FAIL rnd%0d_pc op=%h z=%b: pc_we=%0d ir_we=%0d, required %0d 1",
                 n, op, z, obs_pcwe, obs_irwe, e_pcwe);
      end
      checks++;
      if (obs_memwe !== e_memwe || obs_memre !== e_memre) begin
        errors++;
        $display("FAIL rnd%0d_mem op=%h: we=%0d re=%0d, required %0d %0d",
                 n, op, obs_memwe, obs_memre, e_memwe, e_memre);
      end
      if ((is_r && ra >= 0) || is_i) begin
        checks++;
        if (obs_alu !== 4'(is_r ? ra : ia) || (is_i && obs_ext !== (op inside {6'h0C, 6'h0D, 6'h0E}))) begin
          errors++;
          $display("FAIL rnd%0d_alu op=%h fn=%h: alu=%0d ext=%b, required %0d", n, op, fn,
                   obs_alu, obs_ext, is_r ? ra : ia);
        end
      end
      if (is_br || is_j) begin
        checks++;
        if (obs_last_pcsrc !== (is_j ? 2'd2 : 2'd1)) begin
          errors++;
          $display("FAIL rnd%0d_pcsrc op=%h: got %0d, required %0d", n, op, obs_last_pcsrc, is_j ? 2 : 1);
        end
      end
      checks++;
      if (state_o !== 4'(S_FETCH)) begin
        errors++;
        $display("FAIL rnd%0d_next: state=%0d, required FETCH", n, state_o);
      end
    end
  endtask

  task automatic test_reset_mid;
    int k;
    k = 0; opcode = 6'h23;
    while (state_o != 4'(S_MEM_RD) && k < 10) begin
      mem_ready = 1'b1; @(negedge clk); k++;
    end
    mem_ready = 1'b0; #2;
    checks++;
    if (state_o !== 4'(S_MEM_RD) || mem_re !== 1'b1 || iord !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach: state=%0d mem_re=%b iord=%b, required MEM_RD 1 1", state_o, mem_re, iord);
    end
    reset = 1'b0; #1;
    checks++;
    if (all_out !== 21'd0 || state_o !== 4'(S_IDLE)) begin
      errors++;
      $display("FAIL mid_reset: outputs=%h state=%0d, required 0 and IDLE", all_out, state_o);
    end
    @(negedge clk); reset = 1'b1; @(negedge clk);
    checks++;
    if (state_o !== 4'(S_FETCH)) begin
      errors++;
      $display("FAIL mid_recover: state=%0d, required FETCH", state_o);
    end
  endtask

  task automatic test_timeout;
    int n;
    bit stop;
    n = 0; stop = 0; mem_ready = 1'b0; opcode = 6'($urandom);
    while (!stop && n < 40) begin
      #1;
      if (state_o == 4'(S_FETCH) && ir_we == 1'b0 && bus_err == 1'b0) begin
        n++; @(negedge clk);
      end else begin
        stop = 1;
      end
    end
    checks++;
    if (n !== 15) begin
      errors++;
      $display("FAIL timeout_len: waited %0d cycles in FETCH, required 15", n);
    end
    checks++;
    if (bus_err !== 1'b1 || state_o !== 4'(S_HALT)) begin
      errors++;
      $display("FAIL timeout_halt: bus_err=%b state=%0d, required 1 HALT", bus_err, state_o);
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom); @(negedge clk); #1;
      checks++;
      if (state_o !== 4'(S_HALT) || all_out !== 21'd1) begin
        errors++;
        $display("FAIL halt_hold: outputs=%h state=%0d, required 1 and HALT", all_out, state_o);
      end
    end
    reset = 1'b0; #1;
    checks++;
    if (bus_err !== 1'b0 || state_o !== 4'(S_IDLE)) begin
      errors++;
      $display("FAIL timeout_clear: bus_err=%b state=%0d, required 0 IDLE", bus_err, state_o);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
